// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// read-back phases, byte strides and default memory capacities.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    V_IDLE,
    V_READ,
    V_CMP
  } verify_phase_t;

  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;

  localparam int IMEM_WORDS_DEF = 512;
  localparam int DMEM_WORDS_DEF = 1024;

endpackage

// File: rtl/loader_verify.sv
// Read-back checker: after each write, issues one read at the written address
// and compares the returned word one cycle later against the stored copy.
module loader_verify
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        wr_i,
  input  logic        wr_d,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata,
  input  logic [31:0] rdata_i,
  input  logic [63:0] rdata_d,
  output logic        busy,
  output logic        cmp,
  output logic        mismatch,
  output logic        ren_i,
  output logic        ren_d,
  output logic [63:0] raddr
);

  verify_phase_t phase;
  logic          is_d;
  logic [63:0]   addr_q;
  logic [63:0]   word_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase <= V_IDLE;
      is_d  <= 1'b0;
    end else begin
      unique case (phase)
        V_IDLE: if (wr_i || wr_d) begin
          phase <= V_READ;
          is_d  <= wr_d;
        end
        V_READ:  phase <= V_CMP;
        default: phase <= V_IDLE;
      endcase
    end
  end

  // Address and word copies are data only; the phase register qualifies them.
  always_ff @(posedge clk) begin
    if (wr_i || wr_d) begin
      addr_q <= waddr;
      word_q <= wdata;
    end
  end

  assign busy     = (phase != V_IDLE);
  assign cmp      = (phase == V_CMP);
  assign ren_i    = (phase == V_READ) && !is_d;
  assign ren_d    = (phase == V_READ) && is_d;
  assign raddr    = addr_q;
  assign mismatch = cmp && (is_d ? (rdata_d != word_q) : (rdata_i != word_q[31:0]));

endmodule

// File: rtl/program_loader.sv
// Streams a program image into instruction then data memory and enables the core.
// Optional read-back verification of every write is built with LOADER_VERIFY_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        done,
  output logic        error
);

  localparam int IW = $clog2(IMEM_WORDS + 1);
  localparam int DW = $clog2(DMEM_WORDS + 1);

  loader_state_t state, state_nx;
  logic [IW-1:0] icount;
  logic [DW-1:0] dcount;
  logic          wr_i, wr_d, clr_cnt, busy;
  logic [63:0]   iaddr, daddr;

  assign iaddr = IMEM_STRIDE * 64'(icount);
  assign daddr = DMEM_STRIDE * 64'(dcount);

`ifdef LOADER_VERIFY_EN
  logic        cmp, mismatch, vren_i, vren_d, last_q;
  logic [63:0] raddr;

  loader_verify u_verify (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_i     (wr_i),
    .wr_d     (wr_d),
    .waddr    (wr_i ? iaddr : daddr),
    .wdata    (in_data),
    .rdata_i  (rdata_ext),
    .rdata_d  (rdata_ext_2),
    .busy     (busy),
    .cmp      (cmp),
    .mismatch (mismatch),
    .ren_i    (vren_i),
    .ren_d    (vren_d),
    .raddr    (raddr)
  );

  // The phase change waits for the last word's read-back to pass.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)          last_q <= 1'b0;
    else if (wr_i || wr_d) last_q <= in_last;
  end

  assign ren_ext     = vren_i;
  assign ren_ext_2   = vren_d;
  assign addr_ext    = wr_i ? iaddr : (vren_i ? raddr : 64'd0);
  assign addr_ext_2  = wr_d ? daddr : (vren_d ? raddr : 64'd0);
`else
  logic unused_rdata;

  assign busy         = 1'b0;
  assign unused_rdata = ^{rdata_ext, rdata_ext_2};
  assign ren_ext      = 1'b0;
  assign ren_ext_2    = 1'b0;
  assign addr_ext     = wr_i ? iaddr : 64'd0;
  assign addr_ext_2   = wr_d ? daddr : 64'd0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    wr_i       = 1'b0;
    wr_d       = 1'b0;
    clr_cnt    = 1'b0;
    cpu_enable = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nx = LOAD_I;
        clr_cnt  = 1'b1;
      end
      LOAD_I: begin
        in_ready = !busy;
        if (in_valid && !busy) begin
          if (icount == IW'(IMEM_WORDS)) state_nx = ERROR;
          else begin
            wr_i = 1'b1;
`ifndef LOADER_VERIFY_EN
            if (in_last) state_nx = LOAD_D;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        if (cmp) begin
          if (mismatch)    state_nx = ERROR;
          else if (last_q) state_nx = LOAD_D;
        end
`endif
      end
      LOAD_D: begin
        in_ready = !busy;
        if (in_valid && !busy) begin
          if (dcount == DW'(DMEM_WORDS)) state_nx = ERROR;
          else begin
            wr_d = 1'b1;
`ifndef LOADER_VERIFY_EN
            if (in_last) state_nx = RUN;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        if (cmp) begin
          if (mismatch)    state_nx = ERROR;
          else if (last_q) state_nx = RUN;
        end
`endif
      end
      RUN: begin
        cpu_enable = !start;
        if (start) begin
          state_nx = LOAD_I;
          clr_cnt  = 1'b1;
        end
      end
      ERROR: if (start) begin
        state_nx = LOAD_I;
        clr_cnt  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      icount <= '0;
      dcount <= '0;
    end else if (clr_cnt) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (wr_i) icount <= icount + IW'(1);
      if (wr_d) dcount <= dcount + DW'(1);
    end
  end

  assign wen_ext     = wr_i;
  assign wen_ext_2   = wr_d;
  assign wdata_ext   = wr_i ? in_data[31:0] : 32'd0;
  assign wdata_ext_2 = wr_d ? in_data : 64'd0;
  assign done        = (state == RUN);
  assign error       = (state == ERROR);

endmodule
